disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4: cycles each digit is driven per frame; legal range 1..255.
REQ-002 SHALL have parameter BLANK_LZ, default 1: when 1, a tens digit of 0 is blanked.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: a new two-digit value is offered.
REQ-006 SHALL have port load_tens, input, 4 bits: offered tens digit, BCD.
REQ-007 SHALL have port load_ones, input, 4 bits: offered ones digit, BCD.
REQ-008 SHALL have port load_ready, output, 1 bit: the block can accept a load.
REQ-009 SHALL have port inc, input, 1 bit: a single-cycle request to BCD-increment the displayed value.
REQ-010 SHALL have port seg, output, 7 bits: active-high segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port digit_sel, output, 1 bit: 1 selects the tens digit and 0 selects the ones digit.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL implement the FSM sequence ONES(DWELL cycles) -> GUARD_A(1) -> TENS(DWELL) -> GUARD_B(1) -> ONES, so that a frame is 2*DWELL+2 cycles.
REQ-014 SHALL use a dwell counter that counts 0..DWELL-1 in ONES and TENS, advances the state at DWELL-1, and clears to 0 on every state change.
REQ-015 SHALL register seg, digit_sel and frame_tick, so that their values in cycle n+1 are the decode of the state in cycle n.
REQ-016 SHALL set seg to 0 in GUARD_A and GUARD_B (anti-ghosting), and SHALL set digit_sel to 1 only in TENS.
REQ-017 SHALL decode segments as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); any code from A to F decodes to 00.
REQ-018 SHALL drive seg to 00 in TENS when BLANK_LZ=1 and tens_reg=0; the ones digit is never blanked.
REQ-019 SHALL accept a load when load_valid & load_ready: {load_tens,load_ones} is captured into the pending register, pend_valid is set to 1, and load_ready = !pend_valid.
REQ-020 SHALL capture an inc pulse into the inc_pend flag; any further inc pulses before the boundary are absorbed, giving at most one increment per frame.
REQ-021 SHALL define the frame boundary as the GUARD_B cycle; the displayed digits tens_reg/ones_reg change only there, so there is no tearing within a frame.
REQ-022 SHALL apply the following at the boundary: if pend_valid, load pending into tens_reg/ones_reg; else if inc_pend, BCD-increment the displayed value; in both cases clear pend_valid and inc_pend.
REQ-023 SHALL, when a load and an inc are both pending at the boundary, apply the load and drop the inc.
REQ-024 SHALL, when load_valid or inc arrives in the boundary cycle itself, apply the update being committed in that cycle; the newly arriving request is captured for the next frame.
REQ-025 SHALL perform the BCD increment so that ones 9 -> 0 carries into tens, and 99 wraps to 00.
REQ-026 SHALL pass non-BCD load digits through unchanged, so that they display blank; if inc is applied to a non-BCD value, the result is 00.
REQ-027 SHALL assert frame_tick for exactly one cycle per frame, in the cycle after GUARD_B.

Reset
REQ-028 SHALL, while reset is high: put state in ONES with dwell=0, set tens_reg=ones_reg=0, clear pend_valid and inc_pend, and drive seg=00, digit_sel=0, frame_tick=0, load_ready=1.
REQ-029 SHALL, on reset assertion mid-frame, take effect asynchronously and discard any pending load or inc.
REQ-030 SHALL, after reset deassertion, start the first ONES dwell on the first clock edge, so that seg shows 3F one cycle later.

Verification
REQ-031 SHALL verify scan timing (DWELL=4, idle inputs, after reset): seg=3F/digit_sel=0 for 4 cycles -> 00 for 1 cycle -> 00 with digit_sel=1 for 4 cycles (leading zero blanked) -> 00 for 1 cycle -> frame_tick pulse; period 10 cycles.
REQ-032 SHALL verify load: load 2,3 mid-ONES -> load_ready drops next cycle; the display stays 00 until the boundary, then ones=4F and tens=5B; load_ready returns to 1 at the boundary.
REQ-033 SHALL verify increment wrap: load 9,9, then pulse inc three times within one frame -> exactly one increment, so the display reads 00 (ones 3F, tens blanked) after the next boundary.
REQ-034 SHALL verify the load-versus-inc conflict: load 4,7 and pulse inc in the same frame -> the display shows 47 after the boundary, and no increment is applied in the following frame.
REQ-035 SHALL verify non-BCD handling: load A,5 -> tens seg 00 and ones 6D; then inc -> 00.
REQ-036 SHALL verify reset mid-operation: a load is pending with display 23; assert reset during TENS -> outputs go to reset values immediately, and after deassertion the display shows 00 and load_ready=1.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller.
// Scans ones and tens digits with a blanking guard cycle between them, and
// commits new display values (load or BCD increment) only at the frame
// boundary so a frame never shows a half-updated value.
module disp_scan_ctrl #(
    parameter int DWELL    = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic       load_ready,
    input  logic       inc,
    output logic [6:0] seg,
    output logic       digit_sel,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ST_ONES    = 2'd0,
        ST_GUARD_A = 2'd1,
        ST_TENS    = 2'd2,
        ST_GUARD_B = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic       inc_pend_q, inc_pend_d;
    logic [6:0] seg_q, seg_d;
    logic       digit_sel_q, digit_sel_d;
    logic       frame_tick_q, frame_tick_d;
    logic       boundary;
    logic       accept;

    // BCD digit to active-high segments {g,f,e,d,c,b,a}; non-BCD codes are dark
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Two-digit BCD increment {tens,ones}; 99 wraps, any non-BCD digit gives 00
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (t > 4'd9 || o > 4'd9) begin
            bcd_inc = 8'h00;
        end else if (o == 4'd9) begin
            bcd_inc = (t == 4'd9) ? 8'h00 : {t + 4'd1, 4'd0};
        end else begin
            bcd_inc = {t, o + 4'd1};
        end
    endfunction

    assign boundary   = (state_q == ST_GUARD_B);
    assign accept     = load_valid & ~pend_valid_q;
    assign load_ready = ~pend_valid_q;
    assign seg        = seg_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

    // Scan sequencing: dwell counter restarts on every state change
    always_comb begin
        state_d = state_q;
        dwell_d = 8'd0;
        case (state_q)
            ST_ONES: begin
                if (dwell_q == DWELL_LAST) state_d = ST_GUARD_A;
                else                       dwell_d = dwell_q + 8'd1;
            end
            ST_GUARD_A: state_d = ST_TENS;
            ST_TENS: begin
                if (dwell_q == DWELL_LAST) state_d = ST_GUARD_B;
                else                       dwell_d = dwell_q + 8'd1;
            end
            default: state_d = ST_ONES;
        endcase
    end

    // Request capture and boundary commit; a pending load beats a pending inc
    always_comb begin
        tens_d       = tens_q;
        ones_d       = ones_q;
        pend_d       = accept ? {load_tens, load_ones} : pend_q;
        pend_valid_d = pend_valid_q | accept;
        inc_pend_d   = inc_pend_q | inc;
        if (boundary) begin
            if (pend_valid_q) begin
                {tens_d, ones_d} = pend_q;
            end else if (inc_pend_q) begin
                {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
            end
            pend_valid_d = accept;
            inc_pend_d   = inc;
        end
    end

    // Output decode of the current state, registered one cycle later
    always_comb begin
        seg_d        = 7'h00;
        digit_sel_d  = 1'b0;
        frame_tick_d = boundary;
        case (state_q)
            ST_ONES: seg_d = seg_decode(ones_q);
            ST_TENS: begin
                digit_sel_d = 1'b1;
                if (!(BLANK_LZ != 0 && tens_q == 4'd0)) seg_d = seg_decode(tens_q);
            end
            default: seg_d = 7'h00;
        endcase
    end

    // All state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ONES;
            dwell_q      <= 8'd0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            pend_q       <= 8'd0;
            pend_valid_q <= 1'b0;
            inc_pend_q   <= 1'b0;
            seg_q        <= 7'h00;
            digit_sel_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            inc_pend_q   <= inc_pend_d;
            seg_q        <= seg_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl (DWELL=4, BLANK_LZ=1): a per-cycle vector table for
// scan timing and a load, then hand sequences for increment, conflict,
// non-BCD, boundary-cycle arrival and mid-frame reset.
module tb_disp_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       load_ready;
    logic       inc;
    logic [6:0] seg;
    logic       digit_sel;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct packed {
        logic       lv;
        logic [3:0] lt;
        logic [3:0] lo;
        logic       inc;
        logic [6:0] seg;
        logic       ds;
        logic       ft;
        logic       rdy;
    } vec_t;

    vec_t tbl [30];

    disp_scan_ctrl #(.DWELL(4), .BLANK_LZ(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_tens  (load_tens),
        .load_ones  (load_ones),
        .load_ready (load_ready),
        .inc        (inc),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cyc %0d): got %h, expected %h", nm, cyc - 1, act, exp);
        end
    endtask

    task automatic step(input logic lv, input logic [3:0] lt, input logic [3:0] lo, input logic in);
        load_valid = lv;
        load_tens  = lt;
        load_ones  = lo;
        inc        = in;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int t);
        while (cyc < t) step(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic put(input int i, input logic lv, input logic [3:0] lt, input logic [3:0] lo,
                       input logic in, input logic [6:0] s, input logic ds, input logic ft,
                       input logic rdy);
        tbl[i] = '{lv, lt, lo, in, s, ds, ft, rdy};
    endtask

    initial begin
        // Frame 0: idle scan of 00. Frame 1: load 2,3 mid-ONES. Frame 2: shows 23.
        for (int i = 0; i < 4; i++)  put(i, 0, 0, 0, 0, 7'h3F, 0, 0, 1);
        put(4, 0, 0, 0, 0, 7'h00, 0, 0, 1);
        for (int i = 5; i < 9; i++)  put(i, 0, 0, 0, 0, 7'h00, 1, 0, 1);
        put(9, 0, 0, 0, 0, 7'h00, 0, 1, 1);
        put(10, 0, 0, 0, 0, 7'h3F, 0, 0, 1);
        put(11, 1, 4'd2, 4'd3, 0, 7'h3F, 0, 0, 0);
        put(12, 0, 0, 0, 0, 7'h3F, 0, 0, 0);
        put(13, 0, 0, 0, 0, 7'h3F, 0, 0, 0);
        put(14, 0, 0, 0, 0, 7'h00, 0, 0, 0);
        for (int i = 15; i < 19; i++) put(i, 0, 0, 0, 0, 7'h00, 1, 0, 0);
        put(19, 0, 0, 0, 0, 7'h00, 0, 1, 1);
        for (int i = 20; i < 24; i++) put(i, 0, 0, 0, 0, 7'h4F, 0, 0, 1);
        put(24, 0, 0, 0, 0, 7'h00, 0, 0, 1);
        for (int i = 25; i < 29; i++) put(i, 0, 0, 0, 0, 7'h5B, 1, 0, 1);
        put(29, 0, 0, 0, 0, 7'h00, 0, 1, 1);

        reset = 1'b1;
        load_valid = 1'b0; load_tens = 4'd0; load_ones = 4'd0; inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_seg", seg, 7'h00);
        chk("reset_dsel", {6'd0, digit_sel}, 7'd0);
        chk("reset_ftick", {6'd0, frame_tick}, 7'd0);
        chk("reset_ready", {6'd0, load_ready}, 7'd1);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].lv, tbl[i].lt, tbl[i].lo, tbl[i].inc);
            chk($sformatf("tbl%0d_seg", i), seg, tbl[i].seg);
            chk($sformatf("tbl%0d_dsel", i), {6'd0, digit_sel}, {6'd0, tbl[i].ds});
            chk($sformatf("tbl%0d_ftick", i), {6'd0, frame_tick}, {6'd0, tbl[i].ft});
            chk($sformatf("tbl%0d_ready", i), {6'd0, load_ready}, {6'd0, tbl[i].rdy});
        end

        // Load 99, then three inc pulses in one frame: one increment -> 00
        idle_to(31); step(1, 4'd9, 4'd9, 0);
        idle_to(40); step(0, 0, 0, 0);
        chk("l99_ones", seg, 7'h6F);
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 1);
        idle_to(46); step(0, 0, 0, 1);
        idle_to(50); step(0, 0, 0, 0);
        chk("wrap_ones", seg, 7'h3F);
        idle_to(55); step(0, 0, 0, 0);
        chk("wrap_tens", seg, 7'h00);
        chk("wrap_tens_dsel", {6'd0, digit_sel}, 7'd1);
        idle_to(60); step(0, 0, 0, 0);
        chk("wrap_no_extra", seg, 7'h3F);

        // Load 47 and inc in the same frame: load wins, inc dropped
        step(1, 4'd4, 4'd7, 0); step(0, 0, 0, 1);
        idle_to(70); step(0, 0, 0, 0);
        chk("conf_ones", seg, 7'h07);
        idle_to(75); step(0, 0, 0, 0);
        chk("conf_tens", seg, 7'h66);
        idle_to(80); step(0, 0, 0, 0);
        chk("conf_no_inc", seg, 7'h07);

        // Non-BCD load A,5 then inc -> 00
        step(1, 4'hA, 4'd5, 0);
        idle_to(90); step(0, 0, 0, 0);
        chk("nbcd_ones", seg, 7'h6D);
        idle_to(95); step(0, 0, 0, 0);
        chk("nbcd_tens", seg, 7'h00);
        step(0, 0, 0, 1);
        idle_to(100); step(0, 0, 0, 0);
        chk("nbcd_inc", seg, 7'h3F);

        // Requests arriving in the boundary cycle take effect one frame later
        idle_to(109); step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("bnd_inc_defer", seg, 7'h3F);
        idle_to(120); step(0, 0, 0, 0);
        chk("bnd_inc_apply", seg, 7'h06);
        idle_to(129); step(1, 4'd5, 4'd6, 0);
        chk("bnd_load_ready", {6'd0, load_ready}, 7'd0);
        step(0, 0, 0, 0);
        chk("bnd_load_defer", seg, 7'h06);
        idle_to(140); step(0, 0, 0, 0);
        chk("bnd_load_apply", seg, 7'h7D);

        // Display 23 with 88 pending, reset during TENS
        step(1, 4'd2, 4'd3, 0);
        idle_to(151); step(1, 4'd8, 4'd8, 0);
        idle_to(155); step(0, 0, 0, 0);
        chk("pre_rst_tens", seg, 7'h5B);
        chk("pre_rst_ready", {6'd0, load_ready}, 7'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_seg", seg, 7'h00);
        chk("rst_dsel", {6'd0, digit_sel}, 7'd0);
        chk("rst_ftick", {6'd0, frame_tick}, 7'd0);
        chk("rst_ready", {6'd0, load_ready}, 7'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        step(0, 0, 0, 0);
        chk("post_rst_ones", seg, 7'h3F);
        chk("post_rst_ready", {6'd0, load_ready}, 7'd1);
        idle_to(5); step(0, 0, 0, 0);
        chk("post_rst_tens", seg, 7'h00);
        idle_to(9); step(0, 0, 0, 0);
        chk("post_rst_ftick", {6'd0, frame_tick}, 7'd1);
        step(0, 0, 0, 0);
        chk("post_rst_discard", seg, 7'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
